// File: rtl/bcd_key_pkg.sv
// rtl/bcd_key_pkg.sv - shared types and helpers for the BCD key encoder
package bcd_key_pkg;

    localparam int NUM_KEYS = 10;
    localparam int CODE_W   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        WAIT_REL = 2'd3
    } key_state_e;

    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
    endfunction

    // Index of the lowest set bit; only meaningful for a one-hot input.
    function automatic logic [CODE_W-1:0] onehot_idx(input logic [NUM_KEYS-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - two-flop synchronizer for raw key lines
module key_sync #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bcd_key_encoder.sv
// rtl/bcd_key_encoder.sv - debounced one-hot key bank to BCD code with valid/ready
module bcd_key_encoder
    import bcd_key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16,
    parameter int CNT_W        = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [CODE_W-1:0]   code_out,
    output logic                code_valid,
    input  logic                code_ready,
    output logic                multi_err,
    output logic                busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [NUM_KEYS-1:0] ksync;

    key_state_e          state_q,      state_d;
    logic [NUM_KEYS-1:0] snap_q,       snap_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [CODE_W-1:0]   code_out_q,   code_out_d;
    logic                code_valid_q, code_valid_d;
    logic                multi_err_q,  multi_err_d;
    logic                busy_q,       busy_d;

    key_sync #(
        .W (NUM_KEYS)
    ) u_key_sync (
        .clk (clk),
        .rst (rst),
        .d_i (key_in),
        .q_o (ksync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            cnt_q        <= '0;
            code_out_q   <= '0;
            code_valid_q <= 1'b0;
            multi_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            cnt_q        <= cnt_d;
            code_out_q   <= code_out_d;
            code_valid_q <= code_valid_d;
            multi_err_q  <= multi_err_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        cnt_d       = cnt_q;
        code_out_d  = code_out_q;
        multi_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ksync != '0) begin
                    state_d = DEBOUNCE;
                    snap_d  = ksync;
                    cnt_d   = '0;
                end
            end

            // A pattern change restarts the count even on the terminal cycle.
            DEBOUNCE: begin
                if (ksync == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ksync != snap_q) begin
                    snap_d = ksync;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (is_onehot(snap_q)) begin
                        state_d    = EMIT;
                        code_out_d = onehot_idx(snap_q);
                    end else begin
                        state_d     = WAIT_REL;
                        multi_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            EMIT: begin
                if (code_ready) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end
            end

            WAIT_REL: begin
                if (ksync != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        code_valid_d = (state_d == EMIT);
        busy_d       = (state_d != IDLE);
    end

    assign code_out   = code_out_q;
    assign code_valid = code_valid_q;
    assign multi_err  = multi_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bcd_key_encoder.sv
// tb/tb_bcd_key_encoder.sv - scoreboard bench for bcd_key_encoder
module tb_bcd_key_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] key_in = '0;
    logic [3:0] code_out;
    logic       code_valid;
    logic       code_ready = 1'b0;
    logic       multi_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    int multi_cnt = 0;
    int x0;
    int m0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    bcd_key_encoder #(
        .DEBOUNCE_CYC (16),
        .CNT_W        (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .multi_err  (multi_err),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 2 time units after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("valid_err_exclusive", {31'd0, code_valid & multi_err}, 32'd0);
            if (code_valid && code_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_code", {28'd0, code_out}, 32'hFFFF);
                end else begin
                    check_eq("code", {28'd0, code_out}, {28'd0, exp_q.pop_front()});
                end
            end
            if (multi_err) begin
                multi_cnt++;
            end
        end
    end

    initial begin
        tick(3);
        check_eq("rst_code_out", {28'd0, code_out}, 32'd0);
        check_eq("rst_valid", {31'd0, code_valid}, 32'd0);
        check_eq("rst_multi", {31'd0, multi_err}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick(2);

        // 1: single key, ready high, latency 19 edges
        x0 = xfer_cnt;
        exp_q.push_back(4'd3);
        code_ready = 1'b1;
        key_in = 10'h008;
        tick(18);
        check_eq("t1_valid_early", {31'd0, code_valid}, 32'd0);
        tick(1);
        check_eq("t1_valid_on_time", {31'd0, code_valid}, 32'd1);
        check_eq("t1_code_out", {28'd0, code_out}, 32'd3);
        tick(1);
        check_eq("t1_valid_dropped", {31'd0, code_valid}, 32'd0);
        tick(20);
        key_in = '0;
        tick(25);
        check_eq("t1_one_xfer", xfer_cnt - x0, 32'd1);
        check_eq("t1_idle", {31'd0, busy}, 32'd0);

        // 2: backpressure holds the code
        x0 = xfer_cnt;
        exp_q.push_back(4'd9);
        code_ready = 1'b0;
        key_in = 10'h200;
        tick(50);
        check_eq("t2_valid_held", {31'd0, code_valid}, 32'd1);
        check_eq("t2_code_out", {28'd0, code_out}, 32'd9);
        check_eq("t2_no_xfer_yet", xfer_cnt - x0, 32'd0);
        code_ready = 1'b1;
        tick(1);
        check_eq("t2_valid_cleared", {31'd0, code_valid}, 32'd0);
        key_in = '0;
        tick(25);
        check_eq("t2_one_xfer", xfer_cnt - x0, 32'd1);
        check_eq("t2_idle", {31'd0, busy}, 32'd0);

        // 3: short glitch produces nothing
        x0 = xfer_cnt;
        m0 = multi_cnt;
        key_in = 10'h001;
        tick(10);
        key_in = '0;
        tick(30);
        check_eq("t3_no_xfer", xfer_cnt - x0, 32'd0);
        check_eq("t3_no_multi", multi_cnt - m0, 32'd0);
        check_eq("t3_idle", {31'd0, busy}, 32'd0);
        check_eq("t3_code_retained", {28'd0, code_out}, 32'd9);

        // 4: two keys -> single error pulse
        x0 = xfer_cnt;
        m0 = multi_cnt;
        key_in = 10'h021;
        tick(30);
        check_eq("t4_one_multi", multi_cnt - m0, 32'd1);
        check_eq("t4_no_xfer", xfer_cnt - x0, 32'd0);
        check_eq("t4_busy_wait_rel", {31'd0, busy}, 32'd1);
        key_in = '0;
        tick(10);
        check_eq("t4_busy_release_dbnc", {31'd0, busy}, 32'd1);
        tick(15);
        check_eq("t4_idle", {31'd0, busy}, 32'd0);
        check_eq("t4_still_one_multi", multi_cnt - m0, 32'd1);

        // 5: bouncing press -> exactly one code
        x0 = xfer_cnt;
        exp_q.push_back(4'd4);
        for (int i = 0; i < 6; i++) begin
            key_in = (i % 2 == 0) ? 10'h010 : 10'h000;
            tick(5);
        end
        key_in = 10'h010;
        tick(40);
        key_in = '0;
        tick(25);
        check_eq("t5_one_xfer", xfer_cnt - x0, 32'd1);

        // 6: reset during EMIT, key held through reset
        x0 = xfer_cnt;
        exp_q.push_back(4'd7);
        code_ready = 1'b0;
        key_in = 10'h080;
        tick(25);
        check_eq("t6_valid_before_rst", {31'd0, code_valid}, 32'd1);
        check_eq("t6_code_before_rst", {28'd0, code_out}, 32'd7);
        rst = 1'b1;
        #1;
        check_eq("t6_valid_async_clear", {31'd0, code_valid}, 32'd0);
        check_eq("t6_code_async_clear", {28'd0, code_out}, 32'd0);
        tick(2);
        rst = 1'b0;
        code_ready = 1'b1;
        tick(18);
        check_eq("t6_valid_early", {31'd0, code_valid}, 32'd0);
        tick(1);
        check_eq("t6_reemit_valid", {31'd0, code_valid}, 32'd1);
        check_eq("t6_reemit_code", {28'd0, code_out}, 32'd7);
        tick(5);
        for (int i = 0; i < 8; i++) begin
            key_in = (i % 2 == 0) ? 10'h000 : 10'h080;
            tick(3);
        end
        key_in = '0;
        tick(30);
        check_eq("t6_one_xfer", xfer_cnt - x0, 32'd1);
        check_eq("t6_idle", {31'd0, busy}, 32'd0);
        check_eq("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
